// File: rtl/frame_rr_sched.sv
// Two-requester round-robin frame scheduler.
// A frame is granted to one AXI-Stream source, its length is latched in IDLE,
// the grant is held for exactly len+1 accepted beats, then priority flips to
// the other requester. cnt_limit feeds a downstream count/align block.
//
// state  | meaning
// IDLE   | no frame in flight; samples requesters and their len inputs
// LOAD   | one quiet cycle so downstream sees a stable cnt_limit first
// ACTIVE | granted stream passed through combinationally until tlast beat

module frame_rr_sched #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  sync_reset_n,
  input  logic                  s0_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  output logic                  s0_axis_tready,
  input  logic                  s1_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  output logic                  s1_axis_tready,
  input  logic [15:0]           len0,
  input  logic [15:0]           len1,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tid,
  output logic                  m_axis_tlast,
  output logic [15:0]           cnt_limit,
  output logic                  frame_done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t      state_q;
  logic        grant_q;
  logic        prio_q;
  logic [15:0] beat_cnt_q;
  logic [15:0] limit_q;
  logic        frame_done_q;

  logic        active;
  logic        beat;
  logic        last_cnt;
  logic        winner_d;
  logic        any_req;
  logic [15:0] win_len_d;

  // Arbitration: a lone requester wins outright, a tie goes to prio.
  always_comb begin
    any_req  = s0_axis_tvalid | s1_axis_tvalid;
    winner_d = 1'b0;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      winner_d = prio_q;
    end else if (s1_axis_tvalid) begin
      winner_d = 1'b1;
    end
    win_len_d = winner_d ? len1 : len0;
  end

  // Zero-latency pass-through of the granted stream while ACTIVE.
  always_comb begin
    active         = (state_q == ACTIVE);
    last_cnt       = (beat_cnt_q == 16'd0);
    m_axis_tvalid  = active & (grant_q ? s1_axis_tvalid : s0_axis_tvalid);
    m_axis_tdata   = grant_q ? s1_axis_tdata : s0_axis_tdata;
    s0_axis_tready = active & ~grant_q & m_axis_tready;
    s1_axis_tready = active &  grant_q & m_axis_tready;
    m_axis_tid     = grant_q;
    m_axis_tlast   = active & last_cnt;
    beat           = m_axis_tvalid & m_axis_tready;
    cnt_limit      = limit_q;
    frame_done     = frame_done_q;
    busy           = (state_q != IDLE);
  end

  // Frame sequencing, grant/priority and beat down-counter.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      prio_q       <= 1'b0;
      beat_cnt_q   <= 16'd0;
      limit_q      <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q    <= winner_d;
            limit_q    <= win_len_d;
            beat_cnt_q <= win_len_d;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (beat) begin
            if (last_cnt) begin
              state_q      <= IDLE;
              prio_q       <= ~grant_q;
              frame_done_q <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q - 16'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_rr_sched.sv
// Directed bench for frame_rr_sched: single source, contention, boundary
// lengths, stalls, mid-frame len change and mid-frame reset.

module tb_frame_rr_sched;

  logic        clk = 1'b0;
  logic        sync_reset_n;
  logic        s0_axis_tvalid, s1_axis_tvalid;
  logic [31:0] s0_axis_tdata, s1_axis_tdata;
  logic        s0_axis_tready, s1_axis_tready;
  logic [15:0] len0, len1;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tid, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [15:0] cnt_limit;
  logic        frame_done, busy;

  int n_cmp = 0;
  int n_err = 0;

  frame_rr_sched #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .sync_reset_n   (sync_reset_n),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tready (s1_axis_tready),
    .len0           (len0),
    .len1           (len1),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tid     (m_axis_tid),
    .m_axis_tlast   (m_axis_tlast),
    .cnt_limit      (cnt_limit),
    .frame_done     (frame_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with the requester already valid and m_axis_tready high.
  // len_after is written to the granted len input once the frame is loaded.
  task automatic run_frame(input bit tid, input int len, input int len_after);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
    tick();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("load_trdy", {30'd0, s1_axis_tready, s0_axis_tready}, 32'd0);
    chk("load_limit", 32'(cnt_limit), 32'(len));
    if (tid) len1 = 16'(len_after);
    else     len0 = 16'(len_after);
    tick();
    for (int i = 0; i <= len; i++) begin
      s0_axis_tdata = 32'h1000_0000 + 32'(i);
      s1_axis_tdata = 32'h2000_0000 + 32'(i);
      #1;
      chk("beat_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("beat_tid", 32'(m_axis_tid), 32'(tid));
      chk("beat_tdata", m_axis_tdata, (tid ? 32'h2000_0000 : 32'h1000_0000) + 32'(i));
      chk("beat_tlast", 32'(m_axis_tlast), 32'(i == len));
      chk("beat_trdy", {30'd0, s1_axis_tready, s0_axis_tready}, tid ? 32'd2 : 32'd1);
      if (i == len) chk("beat_limit", 32'(cnt_limit), 32'(len));
      tick();
    end
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_limit"}, 32'(cnt_limit), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_trdy"}, {30'd0, s1_axis_tready, s0_axis_tready}, 32'd0);
  endtask

  initial begin
    bit [15:0] rdy_pat, vld_pat;
    int beats, k;

    sync_reset_n   = 1'b0;
    s0_axis_tvalid = 1'b1;
    s1_axis_tvalid = 1'b0;
    s0_axis_tdata  = '0;
    s1_axis_tdata  = '0;
    len0           = 16'd3;
    len1           = 16'd0;
    m_axis_tready  = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");

    // single source, 4-beat frame
    sync_reset_n = 1'b1;
    run_frame(1'b0, 3, 3);
    s0_axis_tvalid = 1'b0;
    tick();
    chk("single_done_clr", 32'(frame_done), 32'd0);
    chk("single_limit_hold", 32'(cnt_limit), 32'd3);

    // contention from reset: 0,1,0,1 with 2/3/2/3 beats
    sync_reset_n = 1'b0;
    tick();
    len0 = 16'd1;
    len1 = 16'd2;
    s0_axis_tvalid = 1'b1;
    s1_axis_tvalid = 1'b1;
    sync_reset_n = 1'b1;
    run_frame(1'b0, 1, 1);
    run_frame(1'b1, 2, 2);
    run_frame(1'b0, 1, 1);
    run_frame(1'b1, 2, 2);

    // boundary lengths
    s0_axis_tvalid = 1'b0;
    len1 = 16'd0;
    run_frame(1'b1, 0, 0);
    run_frame(1'b1, 0, 0);
    s1_axis_tvalid = 1'b0;
    s0_axis_tvalid = 1'b1;
    len0 = 16'hFFFF;
    run_frame(1'b0, 65535, 65535);

    // stalls on both sides, other requester valid throughout the frame
    len0 = 16'd7;
    tick();
    tick();
    s1_axis_tvalid = 1'b1;
    rdy_pat = 16'b1010_1101_0110_1011;
    vld_pat = 16'b1101_1011_1110_0111;
    beats = 0;
    k = 0;
    while (beats < 8 && k < 200) begin
      m_axis_tready  = rdy_pat[k % 16];
      s0_axis_tvalid = vld_pat[k % 16];
      s0_axis_tdata  = 32'h3000_0000 + 32'(beats);
      #1;
      chk("stall_tvalid", 32'(m_axis_tvalid), 32'(s0_axis_tvalid));
      chk("stall_tid", 32'(m_axis_tid), 32'd0);
      chk("stall_trdy0", 32'(s0_axis_tready), 32'(m_axis_tready));
      chk("stall_trdy1", 32'(s1_axis_tready), 32'd0);
      chk("stall_tlast", 32'(m_axis_tlast), 32'(beats == 7));
      if (s0_axis_tvalid) chk("stall_tdata", m_axis_tdata, 32'h3000_0000 + 32'(beats));
      if (s0_axis_tvalid && m_axis_tready) beats++;
      tick();
      k++;
    end
    chk("stall_beats", 32'(beats), 32'd8);
    chk("stall_done", 32'(frame_done), 32'd1);
    s1_axis_tvalid = 1'b0;
    s0_axis_tvalid = 1'b1;
    m_axis_tready  = 1'b1;

    // len change mid-frame takes effect only on the next frame
    len0 = 16'd5;
    run_frame(1'b0, 5, 2);
    run_frame(1'b0, 2, 2);

    // reset at beat 3 abandons the frame and clears prio
    len0 = 16'd5;
    tick();
    tick();
    tick();
    tick();
    chk("pre_rst_tlast", 32'(m_axis_tlast), 32'd0);
    sync_reset_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    s1_axis_tvalid = 1'b1;
    sync_reset_n = 1'b1;
    run_frame(1'b0, 5, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_rr_sched.md
FRAME_RR_SCHED -- requirements
Module: frame_rr_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of all tdata ports.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port sync_reset_n, input, 1: reset, synchronous to clk and active-low.
REQ-004 SHALL have ports s0_axis_tvalid in 1, s0_axis_tdata in DATA_WIDTH, s0_axis_tready out 1: requester 0 stream.
REQ-005 SHALL have ports s1_axis_tvalid in 1, s1_axis_tdata in DATA_WIDTH, s1_axis_tready out 1: requester 1 stream.
REQ-006 SHALL have ports len0 in 16 and len1 in 16: per-requester frame length minus one.
REQ-007 SHALL have ports m_axis_tvalid out 1, m_axis_tdata out DATA_WIDTH, m_axis_tready in 1: granted stream toward the count/align datapath.
REQ-008 SHALL have ports m_axis_tid out 1, granted requester index, and m_axis_tlast out 1, last beat of frame.
REQ-009 SHALL have port cnt_limit out 16: latched frame limit driving the downstream count/align block.
REQ-010 SHALL have ports frame_done out 1, one-cycle pulse, and busy out 1, high in LOAD and ACTIVE.

Function
REQ-011 SHALL implement states IDLE, LOAD and ACTIVE, plus registers grant (1 b), prio (1 b), beat_cnt (16 b) and limit_reg (16 b).
REQ-012 IDLE transition: if any sN_axis_tvalid is high, grant = winner, limit_reg and beat_cnt = len[winner], next state LOAD.
REQ-013 Winner selection: if only one requester is valid, it wins; if both are valid, requester prio wins.
REQ-014 LOAD: both s*_tready and m_axis_tvalid low for exactly 1 cycle, then ACTIVE; this gives the downstream block a stable cnt_limit before its first beat.
REQ-015 ACTIVE pass-through: m_axis_tvalid = s[grant]_tvalid, m_axis_tdata = s[grant]_tdata, s[grant]_tready = m_axis_tready, all combinational with zero latency.
REQ-016 In ACTIVE, the non-granted tready SHALL be 0; outside ACTIVE, both treadys SHALL be 0.
REQ-017 A beat is m_axis_tvalid & m_axis_tready; each beat with beat_cnt != 0 decrements beat_cnt by 1.
REQ-018 m_axis_tlast = ACTIVE & (beat_cnt == 0), combinational.
REQ-019 A beat with beat_cnt == 0 ends the frame: next state IDLE, prio = ~grant, frame_done = 1 on the next cycle.
REQ-020 Frame length SHALL be len+1 beats: len = 0 gives a single-beat frame; len = 0xFFFF gives 65536 beats, with no wrap and no early end.
REQ-021 Changes to len0/len1 while LOAD or ACTIVE SHALL be ignored until the next IDLE sample.
REQ-022 cnt_limit SHALL equal limit_reg, held constant from LOAD through the end of the frame and retained in IDLE.
REQ-023 If the granted source drops tvalid mid-frame, the grant SHALL be held with no switch and no timeout, even if the other requester is valid.
REQ-024 m_axis_tid = grant, valid whenever m_axis_tvalid is high.
REQ-025 Minimum gap between back-to-back frames SHALL be 2 cycles (IDLE, LOAD).
REQ-026 m_axis_tready low SHALL stall the frame: beat_cnt and state are held, and tdata is held by the source per AXI rules.

Reset
REQ-027 While sync_reset_n == 0 at a clk edge: state = IDLE, grant = 0, prio = 0, beat_cnt = 0, limit_reg = 0.
REQ-028 Reset output values: cnt_limit = 0, frame_done = 0, busy = 0, m_axis_tvalid = 0, m_axis_tlast = 0, s0/s1_axis_tready = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no tlast and no frame_done; arbitration restarts from IDLE with prio = 0.

Verification
REQ-030 Single source: len0 = 3, s0 always valid, m_axis_tready = 1 -> LOAD 1 cycle, then 4 beats with tid = 0, tlast on beat 4, frame_done 1 cycle later, cnt_limit = 3.
REQ-031 Contention: both valid from reset, len0 = 1, len1 = 2 -> frames alternate 0,1,0,1 of 2/3/2/3 beats, 2-cycle gap between frames, non-granted tready always 0.
REQ-032 Boundary lengths: len1 = 0 -> 1-beat frames with tlast on every beat; len0 = 0xFFFF -> exactly 65536 beats before tlast.
REQ-033 Stalls: random m_axis_tready and s0 tvalid gaps, len0 = 7 -> exactly 8 beats delivered, data order preserved, grant never switches mid-frame.
REQ-034 Len change and reset: len0 changed from 5 to 2 mid-frame -> current frame is still 6 beats and the next frame is 3 beats; sync_reset_n pulsed low at beat 3 -> all outputs at reset values, no frame_done, next grant to s0.
